// File: rtl/rx_char_fifo_if.sv
// rx_char_fifo_if: receiver-side character and PIO read/status signals for rx_char_fifo.
interface rx_char_fifo_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic [DATA_W-1:0] par_data_in;
    logic              char_received;
    logic              rd_req;
    logic              ovf_clr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [ADDR_W:0]   fill_count;
    logic              full;
    logic              overflow;

    modport master (
        output par_data_in, char_received, rd_req, ovf_clr,
        input  rd_data, rd_valid, fill_count, full, overflow
    );

    modport slave (
        input  par_data_in, char_received, rd_req, ovf_clr,
        output rd_data, rd_valid, fill_count, full, overflow
    );
endinterface

// File: rtl/rx_char_fifo.sv
// rx_char_fifo: edge-triggered character FIFO between the serial receiver and Nios PIO reads.
module rx_char_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic           clk,
    input  logic           reset,
    rx_char_fifo_if.slave  bus
);
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_ovf, r_char_d, r_req_d;
    logic              w_push_evt, w_pop_evt, w_empty, w_full, w_pop, w_push;

    always_comb begin
        w_push_evt = bus.char_received & ~r_char_d;
        w_pop_evt  = bus.rd_req & ~r_req_d;
        w_empty    = r_count == '0;
        w_full     = r_count == (ADDR_W+1)'(DEPTH);
        w_pop      = w_pop_evt & ~w_empty;
        w_push     = w_push_evt & (~w_full | w_pop);
    end

    // History regs reset high so levels held through reset release are not seen as edges.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_char_d <= 1'b1;
            r_req_d  <= 1'b1;
        end else begin
            r_char_d <= bus.char_received;
            r_req_d  <= bus.rd_req;
            if (w_push) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            r_count <= r_count + (ADDR_W+1)'(w_push) - (ADDR_W+1)'(w_pop);
            if (w_push_evt & w_full & ~w_pop) r_ovf <= 1'b1;
            else if (bus.ovf_clr) r_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset && w_push) r_mem[r_wr_ptr] <= bus.par_data_in;
    end

    assign bus.rd_data    = w_empty ? '0 : r_mem[r_rd_ptr];
    assign bus.rd_valid   = ~w_empty;
    assign bus.fill_count = r_count;
    assign bus.full       = w_full;
    assign bus.overflow   = r_ovf;
endmodule

// File: tb/tb_rx_char_fifo.sv
// tb_rx_char_fifo: scenario tasks plus randomized traffic checked against a queue-based model.
module tb_rx_char_fifo;
    logic clk = 1'b0;
    logic reset;
    int checks = 0;
    int failures = 0;

    rx_char_fifo_if #(.DATA_W(8), .ADDR_W(4)) bus ();
    rx_char_fifo #(.DATA_W(8), .DEPTH(16), .ADDR_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    logic [7:0] q[$];
    logic m_ovf = 1'b0;
    logic m_pc = 1'b1;
    logic m_pr = 1'b1;

    // One clock: model applies the rules to the inputs held during this cycle, then outputs settle.
    task automatic tick();
        bit push, pop, was_full, pop_ok;
        @(posedge clk);
        if (!reset) begin
            q.delete();
            m_ovf = 1'b0;
            m_pc = 1'b1;
            m_pr = 1'b1;
        end else begin
            push = bus.char_received && !m_pc;
            pop = bus.rd_req && !m_pr;
            was_full = q.size() == 16;
            pop_ok = pop && q.size() > 0;
            if (push && was_full && !pop_ok) m_ovf = 1'b1;
            else if (bus.ovf_clr) m_ovf = 1'b0;
            if (pop_ok) void'(q.pop_front());
            if (push && (!was_full || pop_ok)) q.push_back(bus.par_data_in);
            m_pc = bus.char_received;
            m_pr = bus.rd_req;
        end
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus.par_data_in = b;
        bus.char_received = 1'b1;
        tick();
        bus.char_received = 1'b0;
        tick();
    endtask

    task automatic pop_byte();
        bus.rd_req = 1'b1;
        tick();
        bus.rd_req = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        checks += 5;
        if (bus.fill_count !== 5'd0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", bus.fill_count); end
        if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.rd_valid); end
        if (bus.rd_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", bus.rd_data); end
        if (bus.full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", bus.full); end
        if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", bus.overflow); end
    endtask

    task automatic test_single_push();
        bus.par_data_in = 8'h41;
        bus.char_received = 1'b1;
        tick();
        checks += 3;
        if (bus.rd_valid !== 1'b1) begin failures++; $display("FAIL push1_valid got=%b exp=1", bus.rd_valid); end
        if (bus.rd_data !== 8'h41) begin failures++; $display("FAIL push1_data got=%h exp=41", bus.rd_data); end
        if (bus.fill_count !== 5'd1) begin failures++; $display("FAIL push1_fill got=%0d exp=1", bus.fill_count); end
        tick();
        tick();
        bus.char_received = 1'b0;
        tick();
        checks++;
        if (bus.fill_count !== 5'd1) begin failures++; $display("FAIL push1_held got=%0d exp=1", bus.fill_count); end
        pop_byte();
        checks++;
        if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL push1_drain got=%b exp=0", bus.rd_valid); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i));
        push_byte(8'h99);
        checks += 3;
        if (bus.full !== 1'b1) begin failures++; $display("FAIL ovf_full got=%b exp=1", bus.full); end
        if (bus.fill_count !== 5'd16) begin failures++; $display("FAIL ovf_fill got=%0d exp=16", bus.fill_count); end
        if (bus.overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", bus.overflow); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (bus.rd_data !== 8'h10 + 8'(i)) begin failures++; $display("FAIL ovf_seq[%0d] got=%h exp=%h", i, bus.rd_data, 8'h10 + 8'(i)); end
            pop_byte();
        end
        checks += 2;
        if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL ovf_empty_valid got=%b exp=0", bus.rd_valid); end
        if (bus.rd_data !== 8'h00) begin failures++; $display("FAIL ovf_empty_data got=%h exp=00", bus.rd_data); end
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        checks++;
        if (bus.overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", bus.overflow); end
    endtask

    task automatic test_simul_full();
        for (int i = 0; i < 16; i++) push_byte(8'h20 + 8'(i));
        bus.par_data_in = 8'h55;
        bus.char_received = 1'b1;
        bus.rd_req = 1'b1;
        tick();
        bus.char_received = 1'b0;
        bus.rd_req = 1'b0;
        tick();
        checks += 4;
        if (bus.overflow !== 1'b0) begin failures++; $display("FAIL simul_ovf got=%b exp=0", bus.overflow); end
        if (bus.fill_count !== 5'd16) begin failures++; $display("FAIL simul_fill got=%0d exp=16", bus.fill_count); end
        if (bus.full !== 1'b1) begin failures++; $display("FAIL simul_full got=%b exp=1", bus.full); end
        if (bus.rd_data !== 8'h21) begin failures++; $display("FAIL simul_head got=%h exp=21", bus.rd_data); end
        for (int i = 0; i < 15; i++) pop_byte();
        checks++;
        if (bus.rd_data !== 8'h55) begin failures++; $display("FAIL simul_last got=%h exp=55", bus.rd_data); end
        pop_byte();
    endtask

    task automatic test_reset_held();
        push_byte(8'h33);
        bus.char_received = 1'b1;
        bus.rd_req = 1'b1;
        reset = 1'b0;
        tick();
        checks++;
        if (bus.fill_count !== 5'd0) begin failures++; $display("FAIL held_discard got=%0d exp=0", bus.fill_count); end
        tick();
        reset = 1'b1;
        tick();
        tick();
        checks += 2;
        if (bus.fill_count !== 5'd0) begin failures++; $display("FAIL held_release got=%0d exp=0", bus.fill_count); end
        if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL held_valid got=%b exp=0", bus.rd_valid); end
        bus.char_received = 1'b0;
        bus.rd_req = 1'b0;
        tick();
        push_byte(8'h77);
        checks += 2;
        if (bus.fill_count !== 5'd1) begin failures++; $display("FAIL held_push_fill got=%0d exp=1", bus.fill_count); end
        if (bus.rd_data !== 8'h77) begin failures++; $display("FAIL held_push_data got=%h exp=77", bus.rd_data); end
        pop_byte();
    endtask

    task automatic test_wrap();
        push_byte(8'hEE);
        for (int i = 0; i < 40; i++) begin
            bus.par_data_in = 8'(i);
            bus.char_received = 1'b1;
            tick();
            bus.char_received = 1'b0;
            tick();
            checks++;
            if (bus.fill_count !== 5'd2) begin failures++; $display("FAIL wrap_fill[%0d] got=%0d exp=2", i, bus.fill_count); end
            pop_byte();
            checks++;
            if (bus.rd_data !== 8'(i)) begin failures++; $display("FAIL wrap_data[%0d] got=%h exp=%h", i, bus.rd_data, 8'(i)); end
        end
        pop_byte();
        checks++;
        if (bus.rd_valid !== 1'b0) begin failures++; $display("FAIL wrap_empty got=%b exp=0", bus.rd_valid); end
    endtask

    task automatic test_ovf_clr_collision();
        for (int i = 0; i < 17; i++) push_byte(8'hA0 + 8'(i));
        bus.par_data_in = 8'hBB;
        bus.char_received = 1'b1;
        bus.ovf_clr = 1'b1;
        tick();
        bus.char_received = 1'b0;
        bus.ovf_clr = 1'b0;
        checks++;
        if (bus.overflow !== 1'b1) begin failures++; $display("FAIL clr_collide got=%b exp=1", bus.overflow); end
        tick();
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        checks += 2;
        if (bus.overflow !== 1'b0) begin failures++; $display("FAIL clr_alone got=%b exp=0", bus.overflow); end
        if (bus.fill_count !== 5'd16) begin failures++; $display("FAIL clr_fill got=%0d exp=16", bus.fill_count); end
        for (int i = 0; i < 16; i++) pop_byte();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            bus.par_data_in = 8'($urandom);
            bus.char_received = ($urandom_range(0, 99) < 55);
            bus.rd_req = ($urandom_range(0, 99) < (n < 300 ? 25 : 60));
            bus.ovf_clr = ($urandom_range(0, 99) < 5);
            reset = ($urandom_range(0, 999) != 0);
            tick();
            checks += 5;
            if (bus.fill_count !== 5'(q.size())) begin failures++; $display("FAIL rnd_fill[%0d] got=%0d exp=%0d", n, bus.fill_count, q.size()); end
            if (bus.rd_valid !== (q.size() > 0)) begin failures++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", n, bus.rd_valid, q.size() > 0); end
            if (bus.rd_data !== (q.size() > 0 ? q[0] : 8'h00)) begin failures++; $display("FAIL rnd_data[%0d] got=%h exp=%h", n, bus.rd_data, q.size() > 0 ? q[0] : 8'h00); end
            if (bus.full !== (q.size() == 16)) begin failures++; $display("FAIL rnd_full[%0d] got=%b exp=%b", n, bus.full, q.size() == 16); end
            if (bus.overflow !== m_ovf) begin failures++; $display("FAIL rnd_ovf[%0d] got=%b exp=%b", n, bus.overflow, m_ovf); end
        end
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        bus.par_data_in = 8'h00;
        bus.char_received = 1'b0;
        bus.rd_req = 1'b0;
        bus.ovf_clr = 1'b0;
        test_reset();
        test_single_push();
        test_overflow();
        test_simul_full();
        test_reset_held();
        test_wrap();
        test_ovf_clr_collision();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rx_char_fifo.md
Name: rx_char_fifo

Overview:
- Receive-side buffer between the serial receiver's parallel output (parDataIn / charReceived) and the Nios II PIO inputs.
- Captures each received character on the rising edge of the receiver's character-received strobe and stores it in a DEPTH-entry FIFO.
- Presents the oldest character to software, which consumes it by toggling a read-request PIO bit, so no bytes are lost while the CPU is busy.
- Reports fill level, full, and a sticky overflow flag.

Parameters:
- DATA_W, 8: character width in bits.
- DEPTH, 16: FIFO entries; must be a power of 2.
- ADDR_W, 4: log2(DEPTH); pointer width.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- par_data_in  in  DATA_W  received character from the serial receiver; valid while char_received is high.
- char_received  in  1  receiver strobe, level; one character is accepted per rising edge.
- rd_req  in  1  read request from a Nios PIO, level; one pop per rising edge.
- ovf_clr  in  1  level; clears the overflow flag while high.
- rd_data  out  DATA_W  head-of-FIFO character; 0 when empty.
- rd_valid  out  1  high when the FIFO is non-empty.
- fill_count  out  ADDR_W+1  number of stored entries, 0..DEPTH.
- full  out  1  high when fill_count == DEPTH.
- overflow  out  1  sticky; set when a character is dropped because the FIFO is full.

Behaviour:
- Reset (reset==0 at a clk edge):
  - wr_ptr=0, rd_ptr=0, fill_count=0, overflow=0.
  - Resulting outputs: rd_valid=0, full=0, rd_data=0.
  - Edge-detect history registers for char_received and rd_req are set to 1, so a level held high through reset release causes no push or pop.
  - Memory contents are don't-care.
  - Reset asserted mid-operation discards all stored data within the same cycle.
- Edge detection:
  - push_evt = char_received & ~char_received_d.
  - pop_evt = rd_req & ~rd_req_d.
  - Both history registers update every cycle.
- Push:
  - On push_evt in cycle N with the FIFO not full (or with a simultaneous valid pop), par_data_in is written to mem[wr_ptr] at the end of cycle N.
  - wr_ptr increments modulo DEPTH (wraps DEPTH-1 -> 0).
  - The new entry is visible from cycle N+1. Into an empty FIFO: rd_valid=1, rd_data=byte, fill_count=1 in N+1.
- Pop:
  - On pop_evt in cycle M with fill_count>0, rd_ptr increments modulo DEPTH at the end of M.
  - In M+1, rd_data shows the next entry, or 0 with rd_valid=0 if the FIFO became empty.
  - A pop_evt when empty is ignored: no pointer change, no error flag.
- Simultaneous push_evt and pop_evt:
  - Non-empty, non-full: both happen, fill_count unchanged.
  - Full: pop frees a slot, the push is accepted, overflow not set, full stays 1.
  - Empty: the pop is ignored, the push is accepted, fill_count becomes 1.
- Overflow:
  - A push_evt with full=1 and no pop_evt drops the character: memory, pointers and fill_count are unchanged, and overflow is set to 1 at the end of that cycle.
  - overflow remains set until ovf_clr==1 at a clk edge.
  - If ovf_clr and a new overflow event occur in the same cycle, set wins (overflow=1).
- Read path: rd_data = rd_valid ? mem[rd_ptr] : 0. It is combinational from registered pointers and memory, with no extra pipeline stage.
- fill_count, full and rd_valid derive from registered state only; no combinational path from any input to any output.
- Latency: character strobe to rd_valid is 1 cycle; rd_req edge to next rd_data is 1 cycle.

Test Plan:
- Reset, then push 0x41 (char_received 0->1 for 3 cycles) -> exactly one entry; next cycle rd_valid=1, rd_data=0x41, fill_count=1; the held-high cycles add nothing.
- Push 0x10..0x1F (16 bytes), then push 0x99 -> full=1, fill_count=16, overflow=1; pop 16 times -> rd_data sequence 0x10..0x1F, 0x99 never appears, rd_valid=0 after the last pop.
- Fill to 16, then push 0x55 and raise rd_req in the same cycle -> overflow stays 0, fill_count=16, head advances; the final entry read is 0x55.
- Hold char_received=1 and rd_req=1 while reset=0, then release reset with both still high -> fill_count stays 0, no pop; a later 0->1 on char_received pushes normally.
- 40 interleaved push/pop pairs with pushes 0x00..0x27 -> pointers wrap twice, data is read back in order, fill_count never exceeds 2.
- With overflow=1, assert ovf_clr in the same cycle as another overflow push -> overflow=1; assert ovf_clr alone -> overflow=0 next cycle.
